// File: rtl/pmod_keypad_event_pkg.sv
// Shared constants and types for the keypad event block: key/column encodings,
// the 5-bit event record and the press/release tracking states.
package pmod_keypad_event_pkg;

    localparam logic [3:0] KEY_NONE    = 4'hF;
    localparam logic [3:0] COL0_ACTIVE = 4'b1110;
    localparam int         EV_W        = 5;

    typedef struct packed {
        logic       press;
        logic [3:0] code;
    } ev_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Exactly one column strobe low; anything else means the key code is not meaningful.
    function automatic logic onehot_low(input logic [3:0] c);
        case (c)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pmod_keypad_event_fifo.sv
// Small synchronous FIFO for key events; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module pmod_keypad_event_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on a full FIFO frees the slot the simultaneous push writes into.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pmod_keypad_event.sv
// Turns raw keypad scanner output into debounced press/release events: one
// frame code per 4-column scan, debounced over frames, queued in a small FIFO.
import pmod_keypad_event_pkg::*;

module pmod_keypad_event #(
    parameter int STABLE_FRAMES = 3,
    parameter int DEPTH         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    input  logic [3:0] key,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [3:0] ev_code,
    output logic       ev_press,
    output logic       overflow
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

    logic [3:0] col_q;
    logic       frame_end;
    logic       sample;
    logic [3:0] acc;
    logic       acc_set;
    logic       amb;
    logic [3:0] frame_code;
    logic       frame_ok;
    logic [3:0] cand;
    logic [3:0] cnt;
    logic       deb_tick;
    logic       debounced;
    state_t     state;
    state_t     state_next;
    logic [3:0] held;
    logic [3:0] held_next;
    logic       fsm_push;
    ev_t        fsm_ev;
    logic       push_q;
    ev_t        push_ev_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    ev_t        head;

    assign frame_end  = (col == COL0_ACTIVE) && (col_q != COL0_ACTIVE);
    assign sample     = onehot_low(col) && (key != KEY_NONE);
    assign frame_code = (amb || !acc_set) ? KEY_NONE : acc;
    assign debounced  = (cnt == STABLE_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= KEY_NONE;
            acc     <= KEY_NONE;
            acc_set <= 1'b0;
            amb     <= 1'b0;
        end else begin
            col_q <= col;
            // The frame_end cycle's sample opens the new frame.
            if (frame_end) begin
                acc     <= sample ? key : KEY_NONE;
                acc_set <= sample;
                amb     <= 1'b0;
            end else if (sample) begin
                if (!acc_set) begin
                    acc     <= key;
                    acc_set <= 1'b1;
                end else if (key != acc) begin
                    amb <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ok <= 1'b0;
            cand     <= KEY_NONE;
            cnt      <= 4'd0;
            deb_tick <= 1'b0;
        end else begin
            deb_tick <= frame_end && frame_ok;
            if (frame_end) begin
                // The first frame after reset is partial, so it only arms the debouncer.
                frame_ok <= 1'b1;
                if (frame_ok) begin
                    if (frame_code == cand) begin
                        if (cnt != STABLE_N) cnt <= cnt + 4'd1;
                    end else begin
                        cand <= frame_code;
                        cnt  <= 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            held  <= KEY_NONE;
        end else begin
            state <= state_next;
            held  <= held_next;
        end
    end

    always_comb begin
        state_next = state;
        if (deb_tick && debounced) begin
            case (state)
                IDLE:    if (cand != KEY_NONE) state_next = HELD;
                HELD:    if (cand != held)     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        fsm_push  = 1'b0;
        fsm_ev    = '0;
        held_next = held;
        if (deb_tick && debounced) begin
            case (state)
                IDLE: if (cand != KEY_NONE) begin
                    fsm_push  = 1'b1;
                    fsm_ev    = '{press: 1'b1, code: cand};
                    held_next = cand;
                end
                HELD: if (cand != held) begin
                    fsm_push  = 1'b1;
                    fsm_ev    = '{press: 1'b0, code: held};
                    held_next = KEY_NONE;
                end
                default: held_next = KEY_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_q    <= 1'b0;
            push_ev_q <= '0;
            overflow  <= 1'b0;
        end else begin
            push_q    <= fsm_push;
            push_ev_q <= fsm_ev;
            if (push_q && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // Handshake: an event transfers on any cycle with ev_valid && ev_ready; while
    // ev_valid is high and ev_ready low, ev_code/ev_press stay unchanged.
    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;
    assign ev_code  = head.code;
    assign ev_press = head.press;

    pmod_keypad_event_fifo #(
        .W     (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_ev_q),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule
